// File: rtl/inst_loader.sv
// Boot-time program loader: turns a byte stream (16-bit count + big-endian words)
// into instruction-RAM writes and holds the CPU in reset until the image is complete.
module inst_loader #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        DONE   = 3'd3,
        ERR    = 3'd4
    } state_t;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_q, state_d;
    logic [15:0] count_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_idx_q;
    logic [23:0] word_buf_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        cpu_rst_q;
    logic        done_q;
    logic        err_q;

    logic        accept_s;
    logic        last_byte_s;
    logic [15:0] count_full_s;

    // reload wins over a byte offered on the same edge, so that byte is never accepted
    assign in_ready     = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == DATA);
    assign accept_s     = in_valid && in_ready && !reload;
    assign count_full_s = {count_q[15:8], in_data};
    assign last_byte_s  = (byte_idx_q == 2'd3);

    // Next-state decode; the status outputs are registered from this value
    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = CNT_HI;
        end else if (accept_s) begin
            case (state_q)
                CNT_HI: state_d = CNT_LO;
                CNT_LO: begin
                    if (count_full_s == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, count_full_s} > DEPTH_W) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    if (last_byte_s && ((word_idx_q + 16'd1) == count_q)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Stream state, word assembly and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CNT_HI;
            count_q     <= 16'd0;
            word_idx_q  <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_buf_q  <= 24'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            cpu_rst_q   <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_we_q  <= 1'b0;
            cpu_rst_q <= (state_d != DONE);
            done_q    <= (state_d == DONE);
            err_q     <= (state_d == ERR);
            if (reload) begin
                count_q    <= 16'd0;
                word_idx_q <= 16'd0;
                byte_idx_q <= 2'd0;
            end else if (accept_s) begin
                case (state_q)
                    CNT_HI: count_q[15:8] <= in_data;
                    CNT_LO: begin
                        count_q[7:0] <= in_data;
                        word_idx_q   <= 16'd0;
                        byte_idx_q   <= 2'd0;
                    end
                    DATA: begin
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte_s) begin
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= {word_buf_q, in_data};
                            mem_addr_q  <= {14'd0, word_idx_q, 2'b00};
                            word_idx_q  <= word_idx_q + 16'd1;
                        end else begin
                            word_buf_q <= {word_buf_q[15:0], in_data};
                        end
                    end
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: directed scenarios plus randomized images
// checked against a stream-level reference model.
module tb_inst_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, in_valid, reload;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, cpu_rst, done, err;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int passes = 0;

    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];
    logic [1:0]  rel_q[$];
    logic        exp_done, exp_err;

    inst_loader #(.DEPTH(1024)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Record every write and the release status seen alongside it
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
            rel_q.push_back({done, cpu_rst});
        end
    end

    // Reference: header gives the count; complete 4-byte groups become words at i*4
    task automatic model(input bq_t s);
        int cnt, n;
        cnt      = {s[0], s[1]};
        exp_err  = (cnt > 1024);
        exp_done = (cnt == 0);
        if (cnt != 0 && !exp_err) begin
            n = (s.size() - 2) / 4;
            for (int i = 0; i < n && i < cnt; i++)
                exp_q.push_back({32'(i * 4), s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
            exp_done = (n >= cnt);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input int gap_min, input int gap_max);
        foreach (s[i]) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(gap_max, gap_min));
            send_byte(s[i]);
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        got_q.delete();
        exp_q.delete();
        rel_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_outputs: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b, want 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
        else passes++;
    endtask

    task automatic test_two_words();
        bq_t s;
        pulse_reload();
        s = '{8'h00, 8'h02, 8'h34, 8'h01, 8'h11, 8'h00, 8'h30, 8'h02, 8'h00, 8'h20};
        model(s);
        send_stream(s, 0, 0);
        checks++;
        if ({mem_we, done, cpu_rst} !== 3'b110)
            $display("FAIL two_release: got we/done/crst=%b%b%b, want 110", mem_we, done, cpu_rst);
        else passes++;
        idle(2);
        checks++;
        if ({in_ready, mem_we, mem_addr} !== {1'b0, 1'b0, 32'h4})
            $display("FAIL two_after: got rdy=%b we=%b addr=%h, want 0 0 00000004", in_ready, mem_we, mem_addr);
        else passes++;
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL two_nwrites: got %0d, want %0d", got_q.size(), exp_q.size());
        else passes++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL two_write%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_zero_count();
        pulse_reload();
        send_stream('{8'h00, 8'h00}, 0, 0);
        checks++;
        if ({done, cpu_rst, err} !== 3'b100)
            $display("FAIL zero_release: got done/crst/err=%b%b%b, want 100", done, cpu_rst, err);
        else passes++;
        idle(3);
        checks++;
        if (got_q.size() != 0) $display("FAIL zero_nwrites: got %0d, want 0", got_q.size());
        else passes++;
    endtask

    task automatic test_overflow();
        bq_t s;
        pulse_reload();
        s = '{8'h04, 8'h01};
        model(s);
        send_stream(s, 0, 0);
        checks++;
        if ({err, cpu_rst, in_ready, done} !== {exp_err, 1'b1, 1'b0, 1'b0})
            $display("FAIL ovf_status: got err/crst/rdy/done=%b%b%b%b, want %b100", err, cpu_rst, in_ready, done, exp_err);
        else passes++;
        idle(2);
        checks++;
        if (got_q.size() != 0) $display("FAIL ovf_nwrites: got %0d, want 0", got_q.size());
        else passes++;
        pulse_reload();
        checks++;
        if ({err, in_ready, cpu_rst} !== 3'b011)
            $display("FAIL ovf_reload: got err/rdy/crst=%b%b%b, want 011", err, in_ready, cpu_rst);
        else passes++;
    endtask

    task automatic test_gaps();
        pulse_reload();
        model('{8'h00, 8'h01, 8'h3C, 8'h06, 8'hFF, 8'hFF});
        send_stream('{8'h00, 8'h01}, 0, 0);
        send_stream('{8'h3C, 8'h06, 8'hFF, 8'hFF}, 3, 3);
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_q[0]})
            $display("FAIL gap_write: got we=%b %h_%h, want 1 %h", mem_we, mem_addr, mem_wdata, exp_q[0]);
        else passes++;
        idle(1);
        checks++;
        if (mem_we !== 1'b0 || got_q.size() != 1)
            $display("FAIL gap_single: got we=%b nwrites=%0d, want 0 1", mem_we, got_q.size());
        else passes++;
    endtask

    task automatic test_reload_concurrent();
        bq_t a;
        bq_t b;
        pulse_reload();
        a = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        b = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        model(a);
        send_stream(a, 0, 0);
        in_valid = 1'b1; in_data = 8'h77; reload = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; reload = 1'b0;
        model(b);
        send_stream(b, 0, 1);
        idle(2);
        checks++;
        if (got_q.size() != exp_q.size())
            $display("FAIL rld_nwrites: got %0d, want %0d", got_q.size(), exp_q.size());
        else passes++;
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) $display("FAIL rld_write%0d: got %h, want %h", i, got_q[i], exp_q[i]);
            else passes++;
        end
        checks++;
        if (done !== exp_done) $display("FAIL rld_done: got %b, want %b", done, exp_done);
        else passes++;
    endtask

    task automatic test_rst_mid();
        bq_t s;
        pulse_reload();
        send_stream('{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3}, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL rst_mid_outputs: got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b, want 1 0 0 0 1 0 0",
                     in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, err);
        else passes++;
        s = '{8'h00, 8'h01, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        model(s);
        send_stream(s, 0, 0);
        idle(2);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || done !== 1'b1)
            $display("FAIL rst_mid_reload: got n=%0d w=%h done=%b, want n=1 w=%h done=1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 64'd0, done, exp_q[0]);
        else passes++;
    endtask

    task automatic test_random();
        bq_t s;
        int cnt;
        for (int it = 0; it < 6; it++) begin
            pulse_reload();
            s.delete();
            cnt = (it == 5) ? $urandom_range(65535, 1025) : $urandom_range(6, 1);
            s.push_back(8'(cnt >> 8));
            s.push_back(8'(cnt));
            if (it != 5) for (int k = 0; k < 4 * cnt; k++) s.push_back(8'($urandom));
            model(s);
            send_stream(s, 0, 2);
            idle(2);
            checks++;
            if (got_q.size() != exp_q.size())
                $display("FAIL rnd%0d_nwrites: got %0d, want %0d", it, got_q.size(), exp_q.size());
            else passes++;
            foreach (exp_q[i]) if (i < got_q.size()) begin
                checks++;
                if (got_q[i] !== exp_q[i]) $display("FAIL rnd%0d_write%0d: got %h, want %h", it, i, got_q[i], exp_q[i]);
                else passes++;
            end
            checks++;
            if ({done, err, cpu_rst} !== {exp_done, exp_err, !exp_done})
                $display("FAIL rnd%0d_status: got done/err/crst=%b%b%b, want %b%b%b",
                         it, done, err, cpu_rst, exp_done, exp_err, !exp_done);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_count();
        test_overflow();
        test_gaps();
        test_reload_concurrent();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
# inst_loader

Boot-time program loader on the write side of the instruction-memory interface that the CPU fetch path reads. Accepts a byte stream (16-bit word count, then big-endian 32-bit instruction words) and writes each assembled word into instruction RAM at consecutive word-aligned byte addresses. Holds the CPU in reset until the whole image is written, then releases it. Sits in the SoC between the host byte link, the instruction RAM write port and the CPU reset input.

## Interface

- DEPTH, 1024: instruction RAM capacity in 32-bit words; maximum legal word count.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  byte present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- reload  in  1  single-cycle pulse; aborts or restarts loading from the word-count header.
- mem_we  out  1  instruction RAM write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write; always word-aligned, equal to word_index*4.
- mem_wdata  out  32  assembled instruction word.
- cpu_rst  out  1  reset to CPU; high while loading or in error.
- done  out  1  image fully written; CPU released.
- err  out  1  header word count exceeded DEPTH.

## Operation

- A byte is accepted on a rising edge with in_valid && in_ready. No other edge changes stream state.
- in_ready is combinational from state: 1 in CNT_HI, CNT_LO and DATA; 0 in DONE and ERR.
- States:
  - CNT_HI: the accepted byte becomes count[15:8]; go to CNT_LO.
  - CNT_LO: the accepted byte becomes count[7:0].
    - count == 0: go to DONE.
    - count > DEPTH: go to ERR.
    - Otherwise: clear word_index and byte_index, go to DATA.
  - DATA: bytes fill the word MSB-first ({b0,b1,b2,b3}); byte_index is 2 bits and wraps. On acceptance of b3:
    - mem_we is registered high with mem_wdata = word and mem_addr = {word_index,2'b00} zero-extended to 32 bits.
    - word_index increments.
    - If word_index+1 == count, go to DONE.
  - DONE: idle. Only reload or rst leaves it.
  - ERR: idle. Only reload or rst leaves it.
- reload in any state: go to CNT_HI and clear count, word_index and byte_index. A partially assembled word is discarded and produces no write. reload has priority over a byte accepted on the same edge; that byte is dropped.
- cpu_rst, done and err are registered from the state, so they lag the state by one cycle:
  - cpu_rst <= (next state != DONE).
  - done <= (next state == DONE).
  - err <= (next state == ERR).
- word_index and count are 16 bits wide. word_index never exceeds DEPTH-1 when mem_we is high.

## Timing

- Reset values: state CNT_HI, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_rst 1, done 0, err 0, all counters 0.
- Write latency: mem_we goes high in the cycle after the edge that accepts b3, for exactly one cycle. mem_addr and mem_wdata are valid in that cycle and hold their values afterwards.
- Release: done=1 and cpu_rst=0 appear in the same cycle as the last mem_we, so the final write lands on the edge where the CPU leaves reset. The CPU's first fetch (pc 0) therefore sees the complete image.
- Count of 0: cpu_rst falls in the cycle after the CNT_LO byte is accepted; no writes occur.
- Gaps in in_valid stall assembly with no timeout. Back-to-back bytes give at most one write every 4 cycles.
- reload out of DONE: cpu_rst rises in the next cycle and done falls in the same cycle.
- rst mid-load: behaves exactly like reset. No write for the partial word; mem_we is 0 in the following cycle.

## Test plan

- Header 0x0002, then bytes 34 01 11 00 30 02 00 20, valid every cycle.
  - mem_we pulses twice: (addr 0x0, data 0x34011100) and (addr 0x4, data 0x30020020).
  - done=1 and cpu_rst=0 in the cycle of the second pulse.
  - in_ready=0 afterwards.
- Header 0x0000.
  - No mem_we.
  - done=1 and cpu_rst=0 one cycle after the second header byte.
- Header 0x0401 (1025).
  - err=1 one cycle later; cpu_rst stays 1; in_ready=0; no mem_we.
  - A reload pulse then returns to CNT_HI with err=0.
- Header 0x0001, data bytes 3C 06 FF FF with in_valid low for 3 cycles between each byte.
  - A single write (addr 0x0, data 0x3C06FFFF) exactly one cycle after the last byte.
- Header 0x0002, 6 data bytes, then reload asserted together with a valid byte.
  - Exactly one write (word 0); the concurrent byte is ignored.
  - Reloading a header 0x0001 plus 4 bytes writes addr 0x0 again.
- rst asserted for one cycle after 3 data bytes.
  - All outputs return to reset values; no mem_we.
  - A fresh complete stream then loads correctly.
